fsic_io_serdes_tx_frame: RTL and testbench
==========================================

// Module: fsic_io_serdes_tx_frame
// PURPOSE
//  Transmit-side serializer of the FSIC chip-to-chip IO-SERDES link; counterpart to the per-lane rx deserializers.
//  Buffers AXI-Stream beats in a 2-entry FIFO and frames each beat as 12 lanes x pCLK_RATIO ioclk bits.
//  Drives serial_txd/serial_tclk; idle frames (tvalid=0) carry the local rx-ready flag for flow control.
//  Single clock domain (ioclk); the coreclk phase arrives as an input count.
// PARAMETERS
//  pDATA_WIDTH  32  stream data width; fixed 8 nibble lanes (pDATA_WIDTH/4 == 8)
//  pCLK_RATIO   4   ioclk cycles per frame (= bits per lane per frame)
//  pCNT_WIDTH   16  width of the sent-valid-frame counter
// PORTS
//  ioclk             in   1    serial bit clock; all state on posedge except txen_q (negedge)
//  axis_rst_n        in   1    asynchronous active-low reset
//  txen_ctl          in   1    software tx enable request (level)
//  rx_received_data  in   1    remote side already transmitting; also arms tx
//  phase_cnt         in   2    coreclk phase in ioclk cycles, 0..pCLK_RATIO-1
//  s_tdata           in   32   beat data
//  s_tstrb/s_tkeep   in   4/4  beat strobes
//  s_tid/s_tuser     in   2/2  beat id / user
//  s_tlast           in   1    beat last
//  s_tvalid          in   1    beat valid
//  s_tready          out  1    = FIFO not full and txen
//  local_rx_ready    in   1    value sent in every frame's tready bit
//  remote_tready     in   1    remote may accept data; gates FIFO pop
//  txen              out  1    sticky transmit enable
//  frame_start       out  1    1-cycle pulse on the ioclk edge where a frame is loaded
//  serial_tclk       out  1    ioclk & txen_q
//  serial_txd        out  12   lane bits
//  valid_frame_cnt   out  16   count of frames sent with tvalid=1; wraps
// BEHAVIOUR
//  Reset: txen=0, txen_q=0, FIFO empty, frame reg=0, tx_phase=0.
//   Outputs after reset: s_tready=0, frame_start=0, serial_tclk=0, serial_txd=0, valid_frame_cnt=0.
//  FSM IDLE->ARM->RUN, no return except by reset.
//   IDLE: on txen_ctl|rx_received_data -> ARM.
//   ARM: when phase_cnt==pCLK_RATIO-1 -> RUN, txen<=1, load first frame.
//   RUN: tx_phase increments each ioclk, wraps pCLK_RATIO-1->0; a frame loads on each wrap edge.
//   txen_q <= txen on negedge ioclk, so serial_tclk never glitches.
//   Deasserting txen_ctl after RUN has no effect.
//  FIFO: 2 entries. Push on s_tvalid&s_tready.
//   Pop only on a frame-load edge with FIFO non-empty and remote_tready=1.
//   Push and pop on the same edge while full is legal: s_tready is from the registered count, so no push while full.
//   Push while empty, then pop at the next load edge: the beat is sent in that frame. Min latency 1 ioclk.
//  Frame word (lane bit at phase k = bit k of the lane nibble):
//   lanes 7..0 = s_tdata nibbles 7..0; lane 8 = tstrb; lane 9 = tkeep; lane 10 = {tid,tuser}.
//   lane 11 = {1'b0, tlast, tvalid, local_rx_ready}.
//  Idle frame (no pop): all fields 0, tvalid=0, tready bit = local_rx_ready sampled at load.
//  serial_txd = frame_bits[tx_phase] & {12{txen}}; all-zero while txen=0.
//  valid_frame_cnt increments at each pop; wraps 0xFFFF->0.
//  Reset mid-frame clears everything immediately; partially sent frames are dropped.
// TESTING
//  1. Reset, txen_ctl=0, s_tvalid=1 -> s_tready=0, serial_txd=0, serial_tclk=0 indefinitely.
//  2. txen_ctl=1 at phase_cnt=1 -> txen rises at the edge with phase_cnt=3; first frame idle.
//     With local_rx_ready=1, lane11 = 1,0,0,0 over phases 0..3.
//  3. Push tdata=0x87654321, tstrb=0xF, tlast=1, remote_tready=1.
//     Next frame: lane0 bits 1,0,0,0; lane7 bits 0,0,0,1; lane11 = 1,1,1,0. valid_frame_cnt=1.
//  4. remote_tready=0, push 3 beats -> 2 accepted, s_tready=0, idle frames sent.
//     Then remote_tready=1 -> 2 valid frames in order, s_tready returns 1.
//  5. rx_received_data=1 with txen_ctl=0 -> RUN entered at next phase_cnt==3.
//     Then txen_ctl toggled 1->0 -> txen stays 1.
//  6. Preload valid_frame_cnt to 0xFFFF via 65535 beats, send one more -> 0x0000.
//     Assert axis_rst_n=0 mid-frame -> all outputs 0 within the reset.

Source files
------------

// File: rtl/fsic_io_serdes_tx_frame_if.sv
// AXI-Stream beat bundle feeding the IO-SERDES tx framer.
// The master drives a beat; the slave answers with tready.
interface fsic_io_serdes_tx_frame_if #(
    parameter int pDATA_WIDTH = 32
);
    logic [pDATA_WIDTH-1:0]   tdata;
    logic [pDATA_WIDTH/8-1:0] tstrb;
    logic [pDATA_WIDTH/8-1:0] tkeep;
    logic [1:0]               tid;
    logic [1:0]               tuser;
    logic                     tlast;
    logic                     tvalid;
    logic                     tready;

    modport master (
        output tdata, tstrb, tkeep, tid, tuser, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tkeep, tid, tuser, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/fsic_io_serdes_tx_frame.sv
// Tx serializer of the FSIC IO-SERDES link: buffers stream beats in a 2-entry FIFO
// and sends each one as a 12-lane frame, one lane bit per ioclk.
module fsic_io_serdes_tx_frame #(
    parameter int pDATA_WIDTH = 32,
    parameter int pCLK_RATIO  = 4,
    parameter int pCNT_WIDTH  = 16
) (
    input  logic                          ioclk,
    input  logic                          axis_rst_n,
    input  logic                          txen_ctl,
    input  logic                          rx_received_data,
    input  logic [$clog2(pCLK_RATIO)-1:0] phase_cnt,
    fsic_io_serdes_tx_frame_if.slave      s_axis,
    input  logic                          local_rx_ready,
    input  logic                          remote_tready,
    output logic                          txen,
    output logic                          frame_start,
    output logic                          serial_tclk,
    output logic [11:0]                   serial_txd,
    output logic [pCNT_WIDTH-1:0]         valid_frame_cnt
);

    localparam int PW     = $clog2(pCLK_RATIO);
    localparam int LANE_W = pDATA_WIDTH / 8;
    localparam logic [PW-1:0] LAST_PHASE = PW'(pCLK_RATIO - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic [pDATA_WIDTH-1:0] data;
        logic [LANE_W-1:0]      strb;
        logic [LANE_W-1:0]      keep;
        logic [1:0]             id;
        logic [1:0]             user;
        logic                   last;
    } beat_t;

    state_t                      r_state;
    state_t                      w_nextState;
    logic                        r_txen;
    logic                        r_txenQ;
    logic [PW-1:0]               r_txPhase;
    logic [11:0][LANE_W-1:0]     r_frame;
    logic [11:0][LANE_W-1:0]     w_frameNext;
    logic                        r_frameStart;
    beat_t                       r_fifo [2];
    logic                        r_wrPtr;
    logic                        r_rdPtr;
    logic [1:0]                  r_count;
    logic [pCNT_WIDTH-1:0]       r_validCnt;
    beat_t                       w_inBeat;
    beat_t                       w_head;
    logic                        w_load;
    logic                        w_tready;
    logic                        w_push;
    logic                        w_pop;

    // A frame is loaded on the ARM->RUN edge and then on every tx_phase wrap.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (txen_ctl || rx_received_data) begin
                    w_nextState = ST_ARM;
                end
            end
            ST_ARM: begin
                if (phase_cnt == LAST_PHASE) begin
                    w_nextState = ST_RUN;
                    w_load      = 1'b1;
                end
            end
            ST_RUN: begin
                w_load = (r_txPhase == LAST_PHASE);
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ioclk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    assign w_tready = r_txen && (r_count != 2'd2);
    assign w_push   = s_axis.tvalid && w_tready;
    assign w_pop    = w_load && (r_count != 2'd0) && remote_tready;
    assign w_head   = r_fifo[r_rdPtr];

    always_comb begin
        w_inBeat.data = s_axis.tdata;
        w_inBeat.strb = s_axis.tstrb;
        w_inBeat.keep = s_axis.tkeep;
        w_inBeat.id   = s_axis.tid;
        w_inBeat.user = s_axis.tuser;
        w_inBeat.last = s_axis.tlast;
    end

    // Idle frames still carry local_rx_ready so the remote side keeps its flow-control view.
    always_comb begin
        w_frameNext     = '0;
        w_frameNext[11] = LANE_W'({3'b000, local_rx_ready});
        if (w_pop) begin
            for (int i = 0; i < 8; i++) begin
                w_frameNext[i] = w_head.data[i*LANE_W +: LANE_W];
            end
            w_frameNext[8]  = w_head.strb;
            w_frameNext[9]  = w_head.keep;
            w_frameNext[10] = LANE_W'({w_head.id, w_head.user});
            w_frameNext[11] = LANE_W'({1'b0, w_head.last, 1'b1, local_rx_ready});
        end
    end

    always_ff @(posedge ioclk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_txen       <= 1'b0;
            r_txPhase    <= '0;
            r_frame      <= '0;
            r_frameStart <= 1'b0;
            r_validCnt   <= '0;
        end else begin
            r_frameStart <= w_load;
            if (w_load) begin
                r_txen  <= 1'b1;
                r_frame <= w_frameNext;
            end
            if (r_state == ST_RUN) begin
                r_txPhase <= w_load ? '0 : r_txPhase + 1'b1;
            end
            if (w_pop) begin
                r_validCnt <= r_validCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge ioclk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo[i] <= '0;
            end
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wrPtr] <= w_inBeat;
                r_wrPtr         <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Retiming txen onto the falling edge keeps the gated clock free of runt pulses.
    always_ff @(negedge ioclk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_txenQ <= 1'b0;
        end else begin
            r_txenQ <= r_txen;
        end
    end

    always_comb begin
        serial_txd = '0;
        for (int l = 0; l < 12; l++) begin
            serial_txd[l] = r_frame[l][r_txPhase] & r_txen;
        end
    end

    assign s_axis.tready   = w_tready;
    assign txen            = r_txen;
    assign frame_start     = r_frameStart;
    assign serial_tclk     = ioclk & r_txenQ;
    assign valid_frame_cnt = r_validCnt;

endmodule

// File: tb/tb_fsic_io_serdes_tx_frame.sv
// Self-checking bench for fsic_io_serdes_tx_frame: directed steps plus random traffic,
// every cycle compared against a frame-level reference model.
module tb_fsic_io_serdes_tx_frame;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic [1:0]  id;
        logic [1:0]  user;
        logic        last;
    } beat_t;

    logic             ioclk;
    logic             axis_rst_n;
    logic             txen_ctl;
    logic             rx_received_data;
    logic [1:0]       phase_cnt;
    logic             local_rx_ready;
    logic             remote_tready;
    logic             txen;
    logic             frame_start;
    logic             serial_tclk;
    logic [11:0]      serial_txd;
    logic [CNT_W-1:0] valid_frame_cnt;

    fsic_io_serdes_tx_frame_if #(.pDATA_WIDTH(32)) axis ();

    fsic_io_serdes_tx_frame #(
        .pDATA_WIDTH(32),
        .pCLK_RATIO (4),
        .pCNT_WIDTH (CNT_W)
    ) dut (
        .ioclk           (ioclk),
        .axis_rst_n      (axis_rst_n),
        .txen_ctl        (txen_ctl),
        .rx_received_data(rx_received_data),
        .phase_cnt       (phase_cnt),
        .s_axis          (axis.slave),
        .local_rx_ready  (local_rx_ready),
        .remote_tready   (remote_tready),
        .txen            (txen),
        .frame_start     (frame_start),
        .serial_tclk     (serial_tclk),
        .serial_txd      (serial_txd),
        .valid_frame_cnt (valid_frame_cnt)
    );

    initial ioclk = 1'b0;
    always #5 ioclk = ~ioclk;

    // Reference model: beats waiting to go out, the 48-bit word of the frame on the wire,
    // and the bit position within that frame.
    beat_t            mQueue [$];
    bit               mArmed;
    bit               mTxen;
    bit               mTclk;
    bit               mFrameStart;
    int               mPhase;
    logic [47:0]      mFrame;
    logic [CNT_W-1:0] mCnt;

    int nAsserts;
    int nFails;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mQueue.delete();
        mArmed      = 1'b0;
        mTxen       = 1'b0;
        mTclk       = 1'b0;
        mFrameStart = 1'b0;
        mPhase      = 0;
        mFrame      = '0;
        mCnt        = '0;
    endtask

    // Advance the model by one ioclk rising edge using the inputs currently driven.
    task automatic modelEdge();
        bit    load;
        bit    push;
        bit    pop;
        beat_t b;
        beat_t nb;
        push = axis.tvalid && mTxen && (mQueue.size() < 2);
        load = mTxen ? (mPhase == 3) : (mArmed && phase_cnt == 2'd3);
        pop  = load && (mQueue.size() > 0) && remote_tready;
        mTclk = mTxen;
        if (load) begin
            if (pop) begin
                b      = mQueue.pop_front();
                mFrame = {1'b0, b.last, 1'b1, local_rx_ready, b.id, b.user, b.keep, b.strb, b.data};
                mCnt   = mCnt + 1'b1;
            end else begin
                mFrame = {3'b000, local_rx_ready, 44'd0};
            end
        end
        if (push) begin
            nb.data = axis.tdata;
            nb.strb = axis.tstrb;
            nb.keep = axis.tkeep;
            nb.id   = axis.tid;
            nb.user = axis.tuser;
            nb.last = axis.tlast;
            mQueue.push_back(nb);
        end
        if (mTxen) begin
            mPhase = (mPhase + 1) % 4;
        end else if (load) begin
            mPhase = 0;
        end
        mFrameStart = load;
        if (load) mTxen = 1'b1;
        if (txen_ctl || rx_received_data) mArmed = 1'b1;
    endtask

    // One ioclk cycle: model edge, DUT edge, then compare every output 1 time unit later.
    task automatic stepCycle();
        logic [11:0] expTxd;
        modelEdge();
        @(posedge ioclk);
        #1;
        phase_cnt = phase_cnt + 2'd1;
        for (int l = 0; l < 12; l++) begin
            expTxd[l] = mTxen ? mFrame[l*4 + mPhase] : 1'b0;
        end
        checkOutput("s_tready", axis.tready, mTxen && (mQueue.size() < 2));
        checkOutput("txen", txen, mTxen);
        checkOutput("frame_start", frame_start, mFrameStart);
        checkOutput("serial_txd", serial_txd, expTxd);
        checkOutput("serial_tclk", serial_tclk, mTclk);
        checkOutput("valid_frame_cnt", valid_frame_cnt, mCnt);
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic [3:0] strb,
                                 input logic [3:0] keep, input logic [1:0] id, input logic [1:0] user,
                                 input logic last);
        axis.tvalid = valid;
        axis.tdata  = data;
        axis.tstrb  = strb;
        axis.tkeep  = keep;
        axis.tid    = id;
        axis.tuser  = user;
        axis.tlast  = last;
    endtask

    task automatic applyRandomBeat(input logic valid);
        applyStimulus(valid, $urandom, 4'($urandom), 4'($urandom), 2'($urandom), 2'($urandom),
                      1'($urandom));
    endtask

    // Async reset: everything must clear without waiting for a clock edge.
    task automatic resetDut(input int n);
        axis_rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_s_tready", axis.tready, 1'b0);
        checkOutput("rst_txen", txen, 1'b0);
        checkOutput("rst_frame_start", frame_start, 1'b0);
        checkOutput("rst_serial_txd", serial_txd, 12'h000);
        checkOutput("rst_serial_tclk", serial_tclk, 1'b0);
        checkOutput("rst_valid_frame_cnt", valid_frame_cnt, '0);
        repeat (n) begin
            @(posedge ioclk);
            #1;
            phase_cnt = phase_cnt + 2'd1;
        end
        checkOutput("rst_hold_s_tready", axis.tready, 1'b0);
        checkOutput("rst_hold_serial_txd", serial_txd, 12'h000);
        axis_rst_n = 1'b1;
    endtask

    task automatic waitFrameStart(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            stepCycle();
            if (frame_start === 1'b1) ok = 1'b1;
        end
        checkOutput("frame_start_wait", ok, 1'b1);
    endtask

    // Called right after a load edge; collects each lane's bits over the four phases.
    task automatic captureLanes(output logic [11:0][3:0] lanes);
        lanes = '0;
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 12; l++) begin
                lanes[l][k] = serial_txd[l];
            end
            if (k < 3) stepCycle();
        end
    endtask

    task automatic waitTxenRise(input int budget);
        bit         seen;
        logic [1:0] p;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            p = phase_cnt;
            stepCycle();
            if (txen === 1'b1) begin
                seen = 1'b1;
                checkOutput("txen_rise_phase", p, 2'd3);
            end
        end
        checkOutput("txen_rise_seen", seen, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [11:0][3:0] lanes;
        bit               ok;

        nAsserts         = 0;
        nFails           = 0;
        txen_ctl         = 1'b0;
        rx_received_data = 1'b0;
        phase_cnt        = 2'd0;
        local_rx_ready   = 1'b1;
        remote_tready    = 1'b1;
        applyStimulus(1'b1, 32'hDEADBEEF, 4'hF, 4'hF, 2'd0, 2'd0, 1'b0);
        resetDut(3);

        // Not enabled: a valid beat must be ignored and the wire stays quiet.
        repeat (12) stepCycle();
        checkOutput("disabled_tready", axis.tready, 1'b0);
        applyStimulus(1'b0, 32'h0, 4'h0, 4'h0, 2'd0, 2'd0, 1'b0);

        // Enable at phase 1; tx must start on the phase-3 edge with an idle frame.
        for (int i = 0; i < 4 && phase_cnt != 2'd1; i++) stepCycle();
        txen_ctl = 1'b1;
        waitTxenRise(16);
        captureLanes(lanes);
        checkOutput("first_lane11", lanes[11], 4'b0001);
        checkOutput("first_lane0", lanes[0], 4'b0000);

        // One beat pushed on the load edge goes out in the following frame.
        applyStimulus(1'b1, 32'h87654321, 4'hF, 4'hF, 2'd0, 2'd0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 4'h0, 4'h0, 2'd0, 2'd0, 1'b0);
        waitFrameStart(8, ok);
        captureLanes(lanes);
        checkOutput("beat_lane0", lanes[0], 4'b0001);
        checkOutput("beat_lane7", lanes[7], 4'b1000);
        checkOutput("beat_lane8", lanes[8], 4'hF);
        checkOutput("beat_lane11", lanes[11], 4'b0111);
        checkOutput("beat_cnt", valid_frame_cnt, 8'd1);

        // Remote stalls: only two beats fit, idle frames keep flowing.
        remote_tready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            applyRandomBeat(1'b1);
            stepCycle();
        end
        checkOutput("full_tready", axis.tready, 1'b0);
        applyStimulus(1'b0, 32'h0, 4'h0, 4'h0, 2'd0, 2'd0, 1'b0);
        repeat (8) stepCycle();
        checkOutput("stalled_cnt", valid_frame_cnt, 8'd1);
        remote_tready = 1'b1;
        repeat (12) stepCycle();
        checkOutput("drained_cnt", valid_frame_cnt, 8'd3);
        checkOutput("drained_tready", axis.tready, 1'b1);

        // Random traffic, back-pressure and rx-ready values.
        repeat (400) begin
            applyRandomBeat(1'($urandom));
            remote_tready  = ($urandom_range(0, 3) != 0);
            local_rx_ready = 1'($urandom);
            stepCycle();
        end
        applyStimulus(1'b0, 32'h0, 4'h0, 4'h0, 2'd0, 2'd0, 1'b0);
        remote_tready = 1'b1;
        repeat (12) stepCycle();

        // Remote activity alone arms tx; the enable is sticky afterwards.
        txen_ctl = 1'b0;
        resetDut(2);
        rx_received_data = 1'b1;
        waitTxenRise(16);
        rx_received_data = 1'b0;
        txen_ctl = 1'b1;
        repeat (3) stepCycle();
        txen_ctl = 1'b0;
        repeat (8) stepCycle();
        checkOutput("txen_sticky", txen, 1'b1);

        // Counter wrap with continuous traffic.
        local_rx_ready = 1'b1;
        remote_tready  = 1'b1;
        for (int i = 0; i < 2000 && mCnt != '1; i++) begin
            applyRandomBeat(1'b1);
            stepCycle();
        end
        checkOutput("cnt_at_max", valid_frame_cnt, 8'hFF);
        for (int i = 0; i < 16 && mCnt != '0; i++) begin
            applyRandomBeat(1'b1);
            stepCycle();
        end
        checkOutput("cnt_wrap", valid_frame_cnt, 8'h00);

        // Reset in the middle of a frame drops it at once.
        waitFrameStart(8, ok);
        stepCycle();
        stepCycle();
        resetDut(3);
        applyStimulus(1'b0, 32'h0, 4'h0, 4'h0, 2'd0, 2'd0, 1'b0);
        repeat (6) stepCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
